// File: rtl/sm_fetch_pkg.sv
// sm_fetch_pkg: shared fetch-unit state encoding, buffer entry type and PC helpers
package sm_fetch_pkg;
  typedef enum logic {FETCH_RUN, FETCH_FLUSH} fetchState_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction
endpackage

// File: rtl/sm_fetch_if.sv
// sm_fetch_if: instruction-memory read bus (request/grant, in-order read data)
//   master = fetch unit, slave = instruction memory
interface sm_fetch_if;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  modport master(output memReq, memAddr, input memGnt, memRvalid, memRdata);
  modport slave(input memReq, memAddr, output memGnt, memRvalid, memRdata);
endinterface

// File: rtl/sm_fetch_fifo.sv
// sm_fetch_fifo: DEPTH-entry circular prefetch buffer of {pc, instr} entries
//   push/pushData write the tail, pop retires the head, flush empties the buffer;
//   head and count are driven from registers only
module sm_fetch_fifo
  import sm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetchEntry_t                  pushData,
  input  logic                         pop,
  input  logic                         flush,
  output fetchEntry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetchEntry_t buffer [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic doPop;
  // DEPTH need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign doPop = pop && count != '0;
  assign head = buffer[rdPtr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        buffer[wrPtr] <= pushData;
        wrPtr <= bump(wrPtr);
      end
      if (doPop) rdPtr <= bump(rdPtr);
      count <= count + CW'(push) - CW'(doPop);
    end
  end
endmodule

// File: rtl/sm_fetch.sv
// sm_fetch: prefetching instruction fetch unit with redirect flush
//   clk/rst: clock, synchronous active-high reset
//   redirect/redirectPc: restart fetching at a new word address
//   instrValid/instr/instrPc/instrReady: buffered instruction stream to the CPU
//   mem: instruction-memory read bus (master side)
module sm_fetch
  import sm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        instrReady,
  sm_fetch_if.master  mem
);
  localparam int CW = $clog2(DEPTH + 1);
  fetchState_t state;
  logic [31:0] fetchPc;
  logic [31:0] respPc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] outAfterRsp;
  logic grant;
  logic rsp;
  logic push;
  logic pop;
  fetchEntry_t pushData;
  fetchEntry_t head;
  // reserving a buffer slot for every read in flight is what keeps the buffer from overflowing
  assign mem.memReq = !rst && !redirect && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
  assign mem.memAddr = fetchPc;
  assign grant = mem.memReq && mem.memGnt;
  assign rsp = mem.memRvalid && outstanding != '0;
  assign outAfterRsp = outstanding - CW'(rsp);
  assign push = rsp && state == FETCH_RUN && !redirect;
  assign pop = instrValid && instrReady && !redirect;
  assign pushData = {respPc, mem.memRdata};
  assign instrValid = count != '0;
  assign instr = head.instr;
  assign instrPc = head.pc;
  sm_fetch_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pushData(pushData),
    .pop(pop),
    .flush(redirect),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_RUN;
      fetchPc <= RESET_PC;
      respPc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else if (redirect) begin
      // everything still in flight after this cycle's response belongs to the old stream
      fetchPc <= redirectPc;
      respPc <= redirectPc;
      outstanding <= outAfterRsp;
      discard <= outAfterRsp;
      state <= outAfterRsp != '0 ? FETCH_FLUSH : FETCH_RUN;
    end else begin
      outstanding <= outAfterRsp + CW'(grant);
      if (grant) fetchPc <= nextPc(fetchPc);
      if (push) respPc <= nextPc(respPc);
      if (rsp && state == FETCH_FLUSH) begin
        discard <= discard - CW'(1);
        if (discard == CW'(1)) state <= FETCH_RUN;
      end
    end
  end
endmodule
